axi_ahb_req_sched: RTL
======================

# axi_ahb_req_sched

Request scheduler at the AXI front end of the AXI-to-AHB bridge. Arbitrates round-robin between the AXI write-address/write-data channels and the read-address channel, and splits each accepted AXI burst into single-beat AHB commands. Commands go into the addr/state/id/size FIFOs, and write data into the data FIFO, that feed `ahb_controller`. A credit counter bounds the number of beats in flight between command issue and AHB completion.

## Interface
- `OUTST_MAX`, default 8: maximum number of issued but not yet completed beats (1..255).
- `hclk` input 1: clock, rising edge.
- `hresetn` input 1: asynchronous, active-low reset.
- `awvalid`, `awready` in/out 1: AXI write address handshake.
- `awaddr` in 32; `awid` in 9; `awsize` in 3; `awlen` in 8; `awburst` in 2: AW payload.
- `wvalid`, `wready` in/out 1: AXI write data handshake.
- `wdata` in 64; `wlast` in 1: W payload.
- `arvalid`, `arready` in/out 1: AXI read address handshake.
- `araddr` in 32; `arid` in 9; `arsize` in 3; `arlen` in 8; `arburst` in 2: AR payload.
- `cmd_w_en` out 1: single write strobe, common to the addr, state, id and size FIFOs.
- `cmd_addr` out 32; `cmd_write` out 1 (1 = write); `cmd_id` out 9; `cmd_size` out 3: command payload.
- `cmd_fifo_full` in 1: OR of the four command FIFO full flags.
- `data_w_en` out 1; `cmd_data` out 64: data FIFO write strobe and data.
- `data_fifo_full` in 1: data FIFO full flag.
- `beat_done` in 1: one pulse per completed AHB transfer, from the response path.
- `busy` out 1: high when not IDLE or when the credit count is nonzero.
- `proto_err` out 1: registered one-cycle error pulse.

## Operation
- FSM states: IDLE, WR_BURST, RD_BURST. Reset state is IDLE.
- IDLE arbitration:
  - `awready = awvalid & (~arvalid | prio_wr)`.
  - `arready = arvalid & (~awvalid | ~prio_wr)`.
  - Both ready outputs are combinational and only asserted in IDLE.
- On an AW handshake:
  - Latch addr, id, size, burst; load `beats_left = awlen`.
  - Go to WR_BURST; `prio_wr <= 0`.
- On an AR handshake:
  - Latch the same fields from AR; load `beats_left = arlen`.
  - Go to RD_BURST; `prio_wr <= 1`.
- Priority reset value: `prio_wr = 1`, so the first conflict grants write.
- Credit check: `credit_ok = (outst_cnt < OUTST_MAX)`.
- WR_BURST:
  - `wready = ~cmd_fifo_full & ~data_fifo_full & credit_ok`.
  - A beat fires on `wvalid & wready`.
  - On a beat: `cmd_w_en = data_w_en = 1` combinationally; `cmd_data = wdata`; `cmd_write = 1`.
- RD_BURST:
  - A beat fires when `~cmd_fifo_full & credit_ok`.
  - On a beat: `cmd_w_en = 1`, `cmd_write = 0`, `data_w_en = 0`.
- On every beat:
  - `cmd_addr` = current beat address; `cmd_id`, `cmd_size` = latched values.
  - If `beats_left == 0`, return to IDLE; otherwise decrement `beats_left` and advance the address.
- Address advance, with `step = 1 << size` and 32-bit arithmetic:
  - FIXED (00): address unchanged.
  - INCR (01): `addr + step`, wrapping modulo 2^32.
  - WRAP (10): `len_bytes = (len+1) << size`; the low bits `(addr + step) & (len_bytes-1)` are merged into `addr & ~(len_bytes-1)`.
  - Reserved (11): treated as INCR; `proto_err` pulses at address accept.
- `proto_err` also pulses when:
  - `wlast` on a W beat does not equal `(beats_left == 0)`. The beat count governs the burst; the beat is still issued.
  - `beat_done` arrives while `outst_cnt == 0`.
- `outst_cnt` update:
  - `+1` on `cmd_w_en`, `-1` on `beat_done`.
  - Both in the same cycle: unchanged.
  - Saturates at 0.
  - Width is `$clog2(OUTST_MAX+1)`.
- While `hresetn` is low, all outputs are forced to 0, including the combinational ready and strobe outputs.
- Reset mid-burst drops the burst; state, counters, latched fields and `prio_wr` return to reset values.

## Timing
- Address accept to first possible beat strobe: 1 cycle, i.e. the cycle after the AW/AR handshake.
- Sustained rate: 1 beat per cycle when FIFOs are not full and credits are available.
- Last beat to next address accept: 1 cycle, since IDLE occupies one cycle.
- FIFO full flags are sampled combinationally in the same cycle as the strobe. No write is ever issued while the corresponding full flag is high.
- `credit_ok` uses the registered `outst_cnt`. A `beat_done` in the current cycle frees a credit for the next cycle, not the current one.
- `busy`, `proto_err` and `outst_cnt` are registered. All strobes and readies are combinational from registered state plus the named inputs.

## Test plan
- Write INCR: `awaddr=0x1000`, `awsize=3`, `awlen=3`, W always valid, FIFOs empty.
  - Expect 4 consecutive `cmd_w_en`/`data_w_en` with addr 0x1000, 0x1008, 0x1010, 0x1018, `cmd_write=1`, data matching.
  - Expect IDLE after the 4th beat.
- Read WRAP: `araddr=0x2018`, `arsize=3`, `arlen=3`, `arburst=10`.
  - Expect addr 0x2018, 0x2000, 0x2008, 0x2010, `cmd_write=0`, `data_w_en=0`.
- Arbitration: `awvalid` and `arvalid` held high with `len=0`.
  - Expect grants alternating W, R, W, R starting with W after reset, one grant every 2 cycles.
- Backpressure: `cmd_fifo_full` high for 3 cycles mid-burst.
  - Expect no strobes and `wready=0` during those cycles; the burst resumes with the correct next address and no beat lost or duplicated.
- Credits: `OUTST_MAX=2`, `beat_done` held low, `arlen=4`.
  - Expect exactly 2 beats, then a stall.
  - One `beat_done` pulse releases exactly 1 more beat on the following cycle.
- Errors and reset:
  - `wlast=1` on beat 0 of `awlen=1` → one `proto_err` pulse; both beats still issued.
  - `hresetn` low mid-burst → all outputs 0, FSM in IDLE, `outst_cnt=0`.

Source files
------------

// File: rtl/axi_ahb_req_sched.sv
// AXI front-end request scheduler for the AXI-to-AHB bridge.
// Round-robin between AW/W and AR, splits bursts into single-beat commands
// for the command/data FIFOs, and bounds in-flight beats with a credit count.
module axi_ahb_req_sched #(
  parameter int OUTST_MAX = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [8:0]  awid,
  input  logic [2:0]  awsize,
  input  logic [7:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic        wlast,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [8:0]  arid,
  input  logic [2:0]  arsize,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic        cmd_w_en,
  output logic [31:0] cmd_addr,
  output logic        cmd_write,
  output logic [8:0]  cmd_id,
  output logic [2:0]  cmd_size,
  input  logic        cmd_fifo_full,
  output logic        data_w_en,
  output logic [63:0] cmd_data,
  input  logic        data_fifo_full,
  input  logic        beat_done,
  output logic        busy,
  output logic        proto_err
);

  localparam int CW = $clog2(OUTST_MAX + 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  // Fields captured at address accept; addr advances per beat.
  typedef struct packed {
    logic [31:0] addr;
    logic [8:0]  id;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [1:0]  burst;
  } burst_t;

  state_t        state_q, state_d;
  logic          prio_wr_q;
  burst_t        bq;
  logic [7:0]    beats_left_q;
  logic [CW-1:0] outst_q, outst_d;
  logic          busy_q, perr_q, perr_d;

  logic aw_rdy, ar_rdy, w_rdy, beat, wr_beat, aw_hs, ar_hs, credit_ok, last_beat;

  // Address of the beat after the current one (FIXED / INCR / WRAP; reserved acts as INCR).
  function automatic logic [31:0] next_addr(input burst_t b);
    logic [31:0] step, len_bytes, mask;
    step      = 32'd1 << b.size;
    len_bytes = ({24'd0, b.len} + 32'd1) << b.size;
    mask      = len_bytes - 32'd1;
    case (b.burst)
      2'b00:   next_addr = b.addr;
      2'b10:   next_addr = (b.addr & ~mask) | ((b.addr + step) & mask);
      default: next_addr = b.addr + step;
    endcase
  endfunction

  assign credit_ok = (outst_q < CW'(OUTST_MAX));
  assign last_beat = (beats_left_q == 8'd0);
  assign aw_hs     = aw_rdy & awvalid;
  assign ar_hs     = ar_rdy & arvalid;

  // Next-state, arbitration and beat strobes.
  always_comb begin
    state_d = state_q;
    aw_rdy  = 1'b0;
    ar_rdy  = 1'b0;
    w_rdy   = 1'b0;
    beat    = 1'b0;
    wr_beat = 1'b0;
    case (state_q)
      IDLE: begin
        aw_rdy = awvalid & (~arvalid | prio_wr_q);
        ar_rdy = arvalid & (~awvalid | ~prio_wr_q);
        if (aw_rdy)      state_d = WR_BURST;
        else if (ar_rdy) state_d = RD_BURST;
      end
      WR_BURST: begin
        w_rdy   = ~cmd_fifo_full & ~data_fifo_full & credit_ok;
        wr_beat = wvalid & w_rdy;
        beat    = wr_beat;
        if (beat && last_beat) state_d = IDLE;
      end
      RD_BURST: begin
        beat = ~cmd_fifo_full & credit_ok;
        if (beat && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit count and error detection, next values.
  always_comb begin
    outst_d = outst_q;
    if (beat && !(beat_done && outst_q != '0)) outst_d = outst_q + 1'b1;
    else if (!beat && beat_done && outst_q != '0) outst_d = outst_q - 1'b1;
    perr_d = (aw_hs && awburst == 2'b11) || (ar_hs && arburst == 2'b11) ||
             (wr_beat && (wlast != last_beat)) || (beat_done && outst_q == '0);
  end

  // FSM state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Burst context, priority, credits and registered status.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      prio_wr_q    <= 1'b1;
      bq           <= '0;
      beats_left_q <= '0;
      outst_q      <= '0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      if (aw_hs) begin
        bq           <= '{addr: awaddr, id: awid, size: awsize, len: awlen, burst: awburst};
        beats_left_q <= awlen;
        prio_wr_q    <= 1'b0;
      end else if (ar_hs) begin
        bq           <= '{addr: araddr, id: arid, size: arsize, len: arlen, burst: arburst};
        beats_left_q <= arlen;
        prio_wr_q    <= 1'b1;
      end else if (beat && !last_beat) begin
        beats_left_q <= beats_left_q - 8'd1;
        bq.addr      <= next_addr(bq);
      end
      outst_q <= outst_d;
      busy_q  <= (state_d != IDLE) || (outst_d != '0);
      perr_q  <= perr_d;
    end
  end

  // Outputs are held low throughout reset, including the combinational ones.
  assign awready   = hresetn & aw_rdy;
  assign arready   = hresetn & ar_rdy;
  assign wready    = hresetn & w_rdy;
  assign cmd_w_en  = hresetn & beat;
  assign data_w_en = hresetn & wr_beat;
  assign cmd_write = hresetn & (state_q == WR_BURST);
  assign cmd_addr  = (hresetn && state_q != IDLE) ? bq.addr : 32'd0;
  assign cmd_id    = (hresetn && state_q != IDLE) ? bq.id   : 9'd0;
  assign cmd_size  = (hresetn && state_q != IDLE) ? bq.size : 3'd0;
  assign cmd_data  = (hresetn && wr_beat) ? wdata : 64'd0;
  assign busy      = busy_q;
  assign proto_err = perr_q;

endmodule
